// File: rtl/rvh_tlb_miss_sched_pkg.sv
// Shared definitions for the DTLB/ITLB miss scheduler: FSM state encoding
// and default sizing for the ITLB anti-starvation counter.
package rvh_tlb_miss_sched_pkg;

  localparam int unsigned STARVE_LIMIT_DEF     = 4;
  localparam int unsigned STARVE_CNT_WIDTH_DEF = 4;
  localparam int unsigned STATE_W              = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_D_BUSY = 3'd1,
    ST_I_BUSY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_GRANT  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/rvh_tlb_miss_sched.sv
// Miss scheduler sharing the single rvh_mmu translation path between the
// DTLB and ITLB miss ports. Keeps at most one walk outstanding, prefers
// DTLB with an ITLB anti-starvation counter, and drains any in-flight walk
// before forwarding an sfence.vma flush to the MMU.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   dtlb/itlb_miss_req_vld_i       miss request pending from each TLB
//   dtlb/itlb_miss_req_rdy_o       miss accepted (handshake back to TLB)
//   mmu_dtlb/itlb_req_vld_o        gated request towards rvh_mmu
//   mmu_dtlb/itlb_req_rdy_i        rvh_mmu ready per port
//   mmu_dtlb/itlb_resp_vld_i       walk completion per port
//   flush_vld_i / flush_grant_o    flush request (held) / one-cycle completion
//   mmu_flush_vld_o / _grant_i     flush towards rvh_mmu / MMU flush done
//   busy_o                         walk outstanding or flush in progress
module rvh_tlb_miss_sched
  import rvh_tlb_miss_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT     = STARVE_LIMIT_DEF,
  parameter int unsigned STARVE_CNT_WIDTH = STARVE_CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic dtlb_miss_req_vld_i,
  input  logic itlb_miss_req_vld_i,
  output logic dtlb_miss_req_rdy_o,
  output logic itlb_miss_req_rdy_o,
  output logic mmu_dtlb_req_vld_o,
  output logic mmu_itlb_req_vld_o,
  input  logic mmu_dtlb_req_rdy_i,
  input  logic mmu_itlb_req_rdy_i,
  input  logic mmu_dtlb_resp_vld_i,
  input  logic mmu_itlb_resp_vld_i,
  input  logic flush_vld_i,
  output logic mmu_flush_vld_o,
  input  logic mmu_flush_grant_i,
  output logic flush_grant_o,
  output logic busy_o
);

  sched_state_e                state_q, state_d;
  logic                        drain_is_i_q, drain_is_i_d;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                        flush_grant_q;

  logic idle, starved, pick_i, pick_d, dtlb_hs, itlb_hs;

  // Winner selection and request gating; only meaningful in IDLE.
  always_comb begin
    idle    = (state_q == ST_IDLE);
    starved = (starve_cnt_q >= STARVE_CNT_WIDTH'(STARVE_LIMIT));
    pick_i  = itlb_miss_req_vld_i & (~dtlb_miss_req_vld_i | starved);
    pick_d  = dtlb_miss_req_vld_i & ~pick_i;

    // rstn gating keeps every output low while reset is being applied.
    mmu_dtlb_req_vld_o  = rstn & idle & ~flush_vld_i & pick_d;
    mmu_itlb_req_vld_o  = rstn & idle & ~flush_vld_i & pick_i;
    dtlb_hs             = mmu_dtlb_req_vld_o & mmu_dtlb_req_rdy_i;
    itlb_hs             = mmu_itlb_req_vld_o & mmu_itlb_req_rdy_i;
    dtlb_miss_req_rdy_o = dtlb_hs;
    itlb_miss_req_rdy_o = itlb_hs;

    mmu_flush_vld_o = rstn & (state_q == ST_FLUSH);
    busy_o          = rstn & ~idle;
    flush_grant_o   = rstn & flush_grant_q;
  end

  // Next-state, drain side and starvation counter.
  always_comb begin
    state_d      = state_q;
    drain_is_i_d = drain_is_i_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (flush_vld_i)  state_d = ST_FLUSH;
        else if (dtlb_hs) state_d = ST_D_BUSY;
        else if (itlb_hs) state_d = ST_I_BUSY;

        if (itlb_hs || !itlb_miss_req_vld_i) begin
          starve_cnt_d = '0;
        end else if (dtlb_hs && (starve_cnt_q != {STARVE_CNT_WIDTH{1'b1}})) begin
          starve_cnt_d = starve_cnt_q + STARVE_CNT_WIDTH'(1);
        end
      end
      ST_D_BUSY: begin
        if (mmu_dtlb_resp_vld_i) begin
          state_d = flush_vld_i ? ST_FLUSH : ST_IDLE;
        end else if (flush_vld_i) begin
          state_d      = ST_DRAIN;
          drain_is_i_d = 1'b0;
        end
      end
      ST_I_BUSY: begin
        if (mmu_itlb_resp_vld_i) begin
          state_d = flush_vld_i ? ST_FLUSH : ST_IDLE;
        end else if (flush_vld_i) begin
          state_d      = ST_DRAIN;
          drain_is_i_d = 1'b1;
        end
      end
      // Flush is pending; wait only for the response of the outstanding side.
      ST_DRAIN: begin
        if (drain_is_i_q ? mmu_itlb_resp_vld_i : mmu_dtlb_resp_vld_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (mmu_flush_grant_i) state_d = ST_GRANT;
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      drain_is_i_q  <= 1'b0;
      starve_cnt_q  <= '0;
      flush_grant_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_is_i_q  <= drain_is_i_d;
      starve_cnt_q  <= starve_cnt_d;
      flush_grant_q <= (state_d == ST_GRANT);
    end
  end

endmodule

// File: tb/tb_rvh_tlb_miss_sched.sv
// Directed bench for rvh_tlb_miss_sched. Stimulus pushes the expected
// handshake/grant events into a queue; a negedge monitor pops and compares
// whenever the DUT raises a ready or flush grant.
module tb_rvh_tlb_miss_sched;

  logic clk = 1'b0;
  logic rstn;
  logic dtlb_vld, itlb_vld, dtlb_rdy, itlb_rdy;
  logic mmu_dvld, mmu_ivld, mmu_drdy, mmu_irdy, mmu_dresp, mmu_iresp;
  logic flush_vld, mmu_flush_vld, mmu_flush_grant, flush_grant, busy;

  int checks = 0;
  int errors = 0;
  byte sb[$];

  always #5 clk = ~clk;

  rvh_tlb_miss_sched dut (
    .clk                 (clk),
    .rstn                (rstn),
    .dtlb_miss_req_vld_i (dtlb_vld),
    .itlb_miss_req_vld_i (itlb_vld),
    .dtlb_miss_req_rdy_o (dtlb_rdy),
    .itlb_miss_req_rdy_o (itlb_rdy),
    .mmu_dtlb_req_vld_o  (mmu_dvld),
    .mmu_itlb_req_vld_o  (mmu_ivld),
    .mmu_dtlb_req_rdy_i  (mmu_drdy),
    .mmu_itlb_req_rdy_i  (mmu_irdy),
    .mmu_dtlb_resp_vld_i (mmu_dresp),
    .mmu_itlb_resp_vld_i (mmu_iresp),
    .flush_vld_i         (flush_vld),
    .mmu_flush_vld_o     (mmu_flush_vld),
    .mmu_flush_grant_i   (mmu_flush_grant),
    .flush_grant_o       (flush_grant),
    .busy_o              (busy)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input byte ev);
    byte exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %c expected none at %0t", ev, $time);
    end else begin
      exp = sb.pop_front();
      if (exp != ev) begin
        errors++;
        $display("FAIL sb_order: got event %c expected %c at %0t", ev, exp, $time);
      end
    end
  endtask

  // Monitor: any handshake or flush grant must match the next queued event.
  always @(negedge clk) begin
    if (dtlb_rdy === 1'b1)    sb_pop("D");
    if (itlb_rdy === 1'b1)    sb_pop("I");
    if (flush_grant === 1'b1) sb_pop("F");
    if (mmu_dvld === 1'b1 && mmu_ivld === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL mutex: got both mmu vld high expected at most one at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  string order;

  initial begin
    rstn = 1'b0; dtlb_vld = 1'b1; itlb_vld = 1'b0;
    mmu_drdy = 1'b1; mmu_irdy = 1'b1; mmu_dresp = 1'b0; mmu_iresp = 1'b0;
    flush_vld = 1'b0; mmu_flush_grant = 1'b0;

    // Reset: outputs held low even with a request pending.
    tick(); tick();
    neg();
    chk("rst_mmu_dvld", mmu_dvld, 1'b0);
    chk("rst_drdy", dtlb_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flush_vld", mmu_flush_vld, 1'b0);
    chk("rst_flush_grant", flush_grant, 1'b0);
    tick(); dtlb_vld = 1'b0; rstn = 1'b1;
    tick();
    neg();
    chk("post_rst_busy", busy, 1'b0);

    // Single DTLB miss, stray ITLB response, 1-cycle bubble after response.
    tick(); dtlb_vld = 1'b1; sb.push_back("D");
    neg(); chk("s1_mmu_dvld", mmu_dvld, 1'b1);
    tick(); dtlb_vld = 1'b0;
    neg(); chk("s1_busy", busy, 1'b1); chk("s1_no_req", mmu_dvld, 1'b0);
    tick(); mmu_iresp = 1'b1;
    tick(); mmu_iresp = 1'b0;
    neg(); chk("s1_stray_iresp", busy, 1'b1);
    tick(); dtlb_vld = 1'b1; mmu_dresp = 1'b1;
    neg(); chk("s1_resp_cycle_no_req", mmu_dvld, 1'b0);
    tick(); mmu_dresp = 1'b0; sb.push_back("D");
    neg(); chk("s1_idle_after_resp", busy, 1'b0); chk("s1_regrant", mmu_dvld, 1'b1);
    tick(); dtlb_vld = 1'b0;
    tick(); mmu_dresp = 1'b1;
    tick(); mmu_dresp = 1'b0;

    // Both sides requesting, 3-cycle walks: starvation counter forces ITLB.
    order = "DDDDIDDDDI";
    dtlb_vld = 1'b1; itlb_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back(order[k]);
      neg();
      if (k == 4) begin
        checks++;
        if (dut.starve_cnt_q !== 4'd4) begin
          errors++;
          $display("FAIL s2_starve_cnt: got %0d expected 4", dut.starve_cnt_q);
        end
      end
      tick();
      if (k == 9) begin dtlb_vld = 1'b0; itlb_vld = 1'b0; end
      tick(); tick();
      if (order[k] == "D") mmu_dresp = 1'b1; else mmu_iresp = 1'b1;
      tick(); mmu_dresp = 1'b0; mmu_iresp = 1'b0;
    end
    neg(); chk("s2_idle", busy, 1'b0);

    // Flush during an outstanding ITLB walk is held off until the response.
    tick(); itlb_vld = 1'b1; sb.push_back("I");
    neg(); chk("s3_mmu_ivld", mmu_ivld, 1'b1);
    tick(); itlb_vld = 1'b0; flush_vld = 1'b1; dtlb_vld = 1'b1;
    neg(); chk("s3_drain_no_flush", mmu_flush_vld, 1'b0); chk("s3_drain_no_dreq", mmu_dvld, 1'b0);
    tick();
    neg(); chk("s3_drain2_no_flush", mmu_flush_vld, 1'b0); chk("s3_drain_busy", busy, 1'b1);
    tick(); mmu_dresp = 1'b1;
    neg(); chk("s3_wrong_resp_no_flush", mmu_flush_vld, 1'b0);
    tick(); mmu_dresp = 1'b0; mmu_iresp = 1'b1;
    neg(); chk("s3_resp_cycle_no_flush", mmu_flush_vld, 1'b0);
    tick(); mmu_iresp = 1'b0;
    neg(); chk("s3_flush_vld", mmu_flush_vld, 1'b1); chk("s3_flush_no_dreq", mmu_dvld, 1'b0);
    tick();
    tick(); mmu_flush_grant = 1'b1; sb.push_back("F");
    neg(); chk("s3_flush_vld_held", mmu_flush_vld, 1'b1);
    tick(); mmu_flush_grant = 1'b0; flush_vld = 1'b0;
    neg(); chk("s3_grant_no_dreq", mmu_dvld, 1'b0); chk("s3_grant_no_flush", mmu_flush_vld, 1'b0);
    tick(); sb.push_back("D");
    neg(); chk("s3_grant_pulse_one", flush_grant, 1'b0);
    tick(); dtlb_vld = 1'b0;
    tick(); mmu_dresp = 1'b1;
    tick(); mmu_dresp = 1'b0;

    // Flush and miss in the same IDLE cycle: flush wins.
    tick(); flush_vld = 1'b1; dtlb_vld = 1'b1;
    neg(); chk("s4_no_drdy", dtlb_rdy, 1'b0); chk("s4_no_dreq", mmu_dvld, 1'b0);
    tick();
    neg(); chk("s4_flush_vld", mmu_flush_vld, 1'b1);
    tick(); mmu_flush_grant = 1'b1; sb.push_back("F");
    tick(); mmu_flush_grant = 1'b0; flush_vld = 1'b0; sb.push_back("D");
    tick();
    neg(); chk("s4_miss_after_grant", mmu_dvld, 1'b1);
    tick(); dtlb_vld = 1'b0;
    tick(); mmu_dresp = 1'b1;
    tick(); mmu_dresp = 1'b0;

    // MMU back-pressure on the DTLB port for 5 cycles.
    mmu_drdy = 1'b0; dtlb_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      neg();
      chk("s5_vld_held", mmu_dvld, 1'b1);
      chk("s5_no_rdy", dtlb_rdy, 1'b0);
      chk("s5_idle", busy, 1'b0);
      tick();
    end
    mmu_drdy = 1'b1; sb.push_back("D");
    neg(); chk("s5_hs_vld", mmu_dvld, 1'b1);
    tick(); dtlb_vld = 1'b0;
    neg(); chk("s5_busy", busy, 1'b1);

    // Reset mid D_BUSY; stray DTLB response afterwards is ignored.
    rstn = 1'b0; itlb_vld = 1'b1;
    neg();
    chk("s6_rst_busy", busy, 1'b0); chk("s6_rst_ivld", mmu_ivld, 1'b0);
    chk("s6_rst_irdy", itlb_rdy, 1'b0);
    tick(); rstn = 1'b1; mmu_dresp = 1'b1; sb.push_back("I");
    neg();
    chk("s6_idle", busy, 1'b0); chk("s6_ivld", mmu_ivld, 1'b1);
    checks++;
    if (dut.starve_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL s6_starve_cnt: got %0d expected 0", dut.starve_cnt_q);
    end
    tick(); mmu_dresp = 1'b0; itlb_vld = 1'b0;
    neg(); chk("s6_ibusy", busy, 1'b1);
    tick(); mmu_iresp = 1'b1;
    tick(); mmu_iresp = 1'b0;
    neg(); chk("s6_done", busy, 1'b0);

    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
